// File: rtl/pc_fetch_if.sv
// Instruction-memory request/ack bus plus the fetch-to-decode valid/ready handshake.
// The fetch stage uses the master modport; the memory/decode environment uses slave.
interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch stage: fetches the instruction at pc over
// req/ack, presents {pc, inst} to decode, then loads npc; supports flush and misalign trapping.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        misalign_err,
  pc_fetch_if.master  bus
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  localparam logic [1:0] RESET_STATE = (RESET_PC[1:0] != 2'b00) ? S_TRAP : S_FETCH;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] inst_q;
  logic [31:0] drop_pc;

  // Target to fetch once the orphaned request drains; a flush in the drain cycle wins.
  assign drop_pc = flush ? flush_pc : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_STATE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inst_q   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (flush) begin
            pc <= flush_pc;
            if (bus.imem_ack) begin
              req_addr <= flush_pc;
              state    <= (flush_pc[1:0] != 2'b00) ? S_TRAP : S_FETCH;
            end else begin
              // request stays on the bus with its old address until the memory answers
              state <= S_DROP;
            end
          end else if (bus.imem_ack) begin
            inst_q <= bus.imem_rdata;
            state  <= S_VALID;
          end
        end
        S_VALID: begin
          if (flush) begin
            pc       <= flush_pc;
            req_addr <= flush_pc;
            state    <= (flush_pc[1:0] != 2'b00) ? S_TRAP : S_FETCH;
          end else if (bus.id_ready) begin
            pc       <= npc;
            req_addr <= npc;
            state    <= (npc[1:0] != 2'b00) ? S_TRAP : S_FETCH;
          end
        end
        S_DROP: begin
          pc <= drop_pc;
          if (bus.imem_ack) begin
            req_addr <= drop_pc;
            state    <= (drop_pc[1:0] != 2'b00) ? S_TRAP : S_FETCH;
          end
        end
        S_TRAP: begin
          if (flush) begin
            pc       <= flush_pc;
            req_addr <= flush_pc;
            state    <= (flush_pc[1:0] != 2'b00) ? S_TRAP : S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.imem_req  = !rst && ((state == S_FETCH) || (state == S_DROP));
    bus.imem_addr = req_addr;
    bus.if_valid  = !rst && (state == S_VALID);
    bus.if_pc     = pc;
    bus.if_inst   = inst_q;
    misalign_err  = !rst && (state == S_TRAP);
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: walks the fetch/accept/flush/trap scenarios with hand-computed
// expectations, plus a second instance built with a misaligned reset PC.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misalign_err;
  logic        misalign_err_b;

  int n_tests = 0;
  int n_fail  = 0;

  pc_fetch_if bus ();
  pc_fetch_if bus_b ();

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .npc          (npc),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .misalign_err (misalign_err),
    .bus          (bus.master)
  );

  pc_fetch #(.RESET_PC(32'h0000_0002)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .npc          (32'h0),
    .flush        (1'b0),
    .flush_pc     (32'h0),
    .misalign_err (misalign_err_b),
    .bus          (bus_b.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; npc = '0; flush = 1'b0; flush_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    bus_b.imem_ack = 1'b0; bus_b.imem_rdata = '0; bus_b.id_ready = 1'b0;
    step(); step();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);

    // T1: first request right after reset falls, ack one clock later
    rst = 1'b0;
    #1;
    check("t1_req0", {31'b0, bus.imem_req}, 32'd1);
    check("t1_addr0", bus.imem_addr, 32'h0);
    check("b_trap", {31'b0, misalign_err_b}, 32'd1);
    check("b_noreq", {31'b0, bus_b.imem_req}, 32'd0);
    step();
    check("t1_wait_addr", bus.imem_addr, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    step();
    bus.imem_ack = 1'b0;
    check("t1_valid", {31'b0, bus.if_valid}, 32'd1);
    check("t1_pc", bus.if_pc, 32'h0);
    check("t1_inst", bus.if_inst, 32'h0000_0013);
    check("t1_noreq", {31'b0, bus.imem_req}, 32'd0);

    // T2: decode stalls for five clocks while npc wanders
    for (int unsigned i = 0; i < 5; i++) begin
      npc = 32'h1000 + 32'(i * 4);
      step();
      check("t2_valid", {31'b0, bus.if_valid}, 32'd1);
      check("t2_pc", bus.if_pc, 32'h0);
      check("t2_inst", bus.if_inst, 32'h0000_0013);
      check("t2_noreq", {31'b0, bus.imem_req}, 32'd0);
    end
    npc = 32'h4; bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    check("t1_next_req", {31'b0, bus.imem_req}, 32'd1);
    check("t1_next_addr", bus.imem_addr, 32'h4);
    check("t1_next_novalid", {31'b0, bus.if_valid}, 32'd0);

    // zero-wait fetch of 0x4, then accept with npc=0x8
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0040_0093;
    step();
    bus.imem_ack = 1'b0;
    check("zw_pc", bus.if_pc, 32'h4);
    check("zw_inst", bus.if_inst, 32'h0040_0093);
    npc = 32'h8; bus.id_ready = 1'b1;
    step();
    bus.id_ready = 1'b0;
    check("zw_next_addr", bus.imem_addr, 32'h8);

    // T3: flush to 0x100 while 0x8 outstanding, ack arrives three clocks later
    flush = 1'b1; flush_pc = 32'h100;
    step();
    flush = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      check("t3_drop_req", {31'b0, bus.imem_req}, 32'd1);
      check("t3_drop_addr", bus.imem_addr, 32'h8);
      check("t3_drop_novalid", {31'b0, bus.if_valid}, 32'd0);
      step();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hdead_beef;
    step();
    bus.imem_ack = 1'b0;
    check("t3_novalid", {31'b0, bus.if_valid}, 32'd0);
    check("t3_req", {31'b0, bus.imem_req}, 32'd1);
    check("t3_addr", bus.imem_addr, 32'h100);

    // T4: flush and ack in the same cycle
    flush = 1'b1; flush_pc = 32'h180; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0bad_0bad;
    step();
    flush = 1'b0; bus.imem_ack = 1'b0;
    check("t4_novalid", {31'b0, bus.if_valid}, 32'd0);
    check("t4_req", {31'b0, bus.imem_req}, 32'd1);
    check("t4_addr", bus.imem_addr, 32'h180);

    // T6: flush and id_ready together in S_VALID
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0011;
    step();
    bus.imem_ack = 1'b0;
    check("t6_pc", bus.if_pc, 32'h180);
    check("t6_inst", bus.if_inst, 32'h0000_0011);
    flush = 1'b1; flush_pc = 32'h300; bus.id_ready = 1'b1; npc = 32'h184;
    step();
    flush = 1'b0; bus.id_ready = 1'b0;
    check("t6_novalid", {31'b0, bus.if_valid}, 32'd0);
    check("t6_addr", bus.imem_addr, 32'h300);

    // T5: accept with misaligned npc traps; aligned flush recovers
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0022;
    step();
    bus.imem_ack = 1'b0;
    check("t5_pc", bus.if_pc, 32'h300);
    npc = 32'h102; bus.id_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("t5_err", {31'b0, misalign_err}, 32'd1);
      check("t5_noreq", {31'b0, bus.imem_req}, 32'd0);
      check("t5_novalid", {31'b0, bus.if_valid}, 32'd0);
    end
    bus.id_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h200;
    step();
    flush = 1'b0;
    check("t5_err_clr", {31'b0, misalign_err}, 32'd0);
    check("t5_req", {31'b0, bus.imem_req}, 32'd1);
    check("t5_addr", bus.imem_addr, 32'h200);

    // misaligned flush target from S_VALID traps; aligned flush leaves
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0033;
    step();
    bus.imem_ack = 1'b0;
    flush = 1'b1; flush_pc = 32'h203;
    step();
    flush = 1'b0;
    check("mf_err", {31'b0, misalign_err}, 32'd1);
    check("mf_noreq", {31'b0, bus.imem_req}, 32'd0);
    flush = 1'b1; flush_pc = 32'h40;
    step();
    flush = 1'b0;
    check("mf_err_clr", {31'b0, misalign_err}, 32'd0);
    check("mf_addr", bus.imem_addr, 32'h40);

    // reset mid-fetch drops the request
    rst = 1'b1;
    #1;
    check("rst_mid_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_addr", bus.imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
